cdb_broadcaster: RTL and testbench

- Transmitting end of the result-tag CAM bus that every reservation station snoops (`depins`/`depinval`).
- Collects completed results (ROB tag + 8-bit value) from up to NSRC functional units.
- Buffers each unit's results in a small per-source FIFO and arbitrates round-robin.
- Broadcasts at most one tag/value pair per cycle on registered outputs. When nothing is broadcast it drives a reserved idle tag, so no station can false-match.

---
 rtl/cdb_broadcaster.sv | 126 ++++++++++++
 tb/tb_cdb_broadcaster.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// Result-tag broadcast bus driver: per-source FIFOs feeding a round-robin
// arbiter that puts at most one tag/value pair per cycle on registered outputs.
module cdb_broadcaster #(
  parameter int         NSRC       = 4,
  parameter int         FIFO_DEPTH = 2,
  parameter logic [3:0] IDLE_TAG   = 4'hF,
  localparam int        SW         = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC-1:0][3:0] src_tag,
  input  logic [NSRC-1:0][7:0] src_val,
  output logic                 cdb_valid,
  output logic [3:0]           cdb_tag,
  output logic [7:0]           cdb_val,
  output logic [SW-1:0]        cdb_src,
  output logic                 err_idle_tag,
  output logic [15:0]          bcast_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [3:0]    fifo_tag [NSRC][FIFO_DEPTH];
  logic [7:0]    fifo_val [NSRC][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr   [NSRC];
  logic [PW-1:0] wr_ptr   [NSRC];
  logic [CW-1:0] cnt      [NSRC];
  logic [SW-1:0] rr_ptr;

  logic [NSRC-1:0] push;
  logic [NSRC-1:0] wr_en;
  logic [NSRC-1:0] pop;
  logic            have_win;
  logic [SW-1:0]   win;
  logic [3:0]      head_tag;
  logic [7:0]      head_val;

  // Readiness comes from the registered count only, so a full FIFO that pops
  // this cycle still refuses a new result.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = (cnt[i] < CW'(FIFO_DEPTH)) & ~rst;
      push[i]      = src_valid[i] & src_ready[i];
      wr_en[i]     = push[i] & (src_tag[i] != IDLE_TAG);
    end
  end

  always_comb begin
    int idx;
    idx      = 0;
    have_win = 1'b0;
    win      = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(rr_ptr) + k) % NSRC;
      if (!have_win && (cnt[idx] != '0)) begin
        have_win = 1'b1;
        win      = SW'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      pop[i] = have_win && (win == SW'(i));
    end
  end

  assign head_tag = fifo_tag[win][rd_ptr[win]];
  assign head_val = fifo_val[win][rd_ptr[win]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (wr_en[i]) begin
        fifo_tag[i][wr_ptr[i]] <= src_tag[i];
        fifo_val[i][wr_ptr[i]] <= src_val[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(wr_en[i]) - CW'(pop[i]);
      end
      if (have_win) rr_ptr <= (win == SW'(NSRC - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid    <= 1'b0;
      cdb_tag      <= IDLE_TAG;
      cdb_val      <= '0;
      cdb_src      <= '0;
      err_idle_tag <= 1'b0;
      bcast_count  <= '0;
    end else begin
      if (have_win) begin
        cdb_valid   <= 1'b1;
        cdb_tag     <= head_tag;
        cdb_val     <= head_val;
        cdb_src     <= win;
        bcast_count <= bcast_count + 16'd1;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag   <= IDLE_TAG;
        cdb_val   <= '0;
        cdb_src   <= '0;
      end
      if ((push & ~wr_en) != '0) err_idle_tag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed scenarios plus random traffic checked
// against a queue-based model of the broadcast rules.
module tb_cdb_broadcaster;
  localparam int NSRC  = 4;
  localparam int DEPTH = 2;

  typedef struct {
    logic [3:0] tag;
    logic [7:0] val;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC-1:0][3:0] src_tag;
  logic [NSRC-1:0][7:0] src_val;
  logic                 cdb_valid;
  logic [3:0]           cdb_tag;
  logic [7:0]           cdb_val;
  logic [1:0]           cdb_src;
  logic                 err_idle_tag;
  logic [15:0]          bcast_count;

  cdb_broadcaster #(.NSRC(NSRC), .FIFO_DEPTH(DEPTH), .IDLE_TAG(4'hF)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_val(src_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_src(cdb_src), .err_idle_tag(err_idle_tag), .bcast_count(bcast_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t        mq   [NSRC][$];
  ent_t        stim [NSRC][$];
  int          m_rr = 0;
  logic [15:0] m_cnt = 0;
  logic        m_err = 0;
  logic        e_valid = 0;
  logic [3:0]  e_tag = 4'hF;
  logic [7:0]  e_val = 0;
  logic [1:0]  e_src = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    logic [NSRC-1:0] rdy;
    logic [NSRC-1:0] acc;
    int g;
    @(negedge clk);
    for (int i = 0; i < NSRC; i++) begin
      if (!src_valid[i] && stim[i].size() > 0) begin
        ent_t e;
        e = stim[i].pop_front();
        src_valid[i] = 1'b1;
        src_tag[i]   = e.tag;
        src_val[i]   = e.val;
      end
    end
    #1;
    for (int i = 0; i < NSRC; i++) rdy[i] = !rst && (mq[i].size() < DEPTH);
    chk("src_ready", 32'(src_ready), 32'(rdy));
    @(posedge clk);
    acc = '0;
    if (rst) begin
      for (int i = 0; i < NSRC; i++) mq[i].delete();
      m_rr = 0; m_cnt = 0; m_err = 0;
      e_valid = 0; e_tag = 4'hF; e_val = 0; e_src = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NSRC; k++)
        if (g < 0 && mq[(m_rr + k) % NSRC].size() > 0) g = (m_rr + k) % NSRC;
      if (g >= 0) begin
        ent_t h;
        h = mq[g].pop_front();
        e_valid = 1; e_tag = h.tag; e_val = h.val; e_src = 2'(g);
        m_rr = (g + 1) % NSRC;
        m_cnt = m_cnt + 16'd1;
      end else begin
        e_valid = 0; e_tag = 4'hF; e_val = 0; e_src = 0;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (src_valid[i] && rdy[i]) begin
          acc[i] = 1'b1;
          if (src_tag[i] == 4'hF) m_err = 1;
          else mq[i].push_back('{src_tag[i], src_val[i]});
        end
      end
    end
    #1;
    chk("cdb_valid", 32'(cdb_valid), 32'(e_valid));
    chk("cdb_tag", 32'(cdb_tag), 32'(e_tag));
    chk("cdb_val", 32'(cdb_val), 32'(e_val));
    chk("cdb_src", 32'(cdb_src), 32'(e_src));
    chk("err_idle_tag", 32'(err_idle_tag), 32'(m_err));
    chk("bcast_count", 32'(bcast_count), 32'(m_cnt));
    for (int i = 0; i < NSRC; i++) if (acc[i]) src_valid[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src_valid = '0;
    src_tag = '0;
    src_val = '0;

    // Reset, then idle
    step(); step();
    chk("ready_in_rst", 32'(src_ready), 32'h0);
    rst = 1'b0;
    repeat (5) step();
    chk("ready_idle", 32'(src_ready), 32'hF);
    chk("idle_tag", 32'(cdb_tag), 32'hF);

    // Single push on source 2
    stim[2].push_back('{4'h3, 8'hA5});
    step();
    chk("single_not_yet", 32'(cdb_valid), 32'h0);
    step();
    chk("single_tag", 32'(cdb_tag), 32'h3);
    chk("single_val", 32'(cdb_val), 32'hA5);
    chk("single_src", 32'(cdb_src), 32'h2);
    step();
    chk("single_held_once", 32'(cdb_tag), 32'hF);
    chk("single_count", 32'(bcast_count), 32'h1);

    // All four sources at once from rr_ptr=0
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NSRC; i++) stim[i].push_back('{4'(i + 4), 8'(8'h10 + i)});
    step();
    for (int i = 0; i < NSRC; i++) begin
      step();
      chk("burst_order", 32'(cdb_src), 32'(i));
    end
    stim[0].push_back('{4'h9, 8'h90});
    stim[3].push_back('{4'hA, 8'hA0});
    step();
    step();
    chk("rr_second_0", 32'(cdb_src), 32'h0);
    step();
    chk("rr_second_3", 32'(cdb_src), 32'h3);
    step();

    // Source 1 back-to-back
    stim[1].push_back('{4'h1, 8'h11});
    stim[1].push_back('{4'h2, 8'h22});
    stim[1].push_back('{4'h4, 8'h44});
    repeat (6) step();

    // Idle-tag guard
    stim[0].push_back('{4'hF, 8'h55});
    repeat (3) step();
    chk("err_set", 32'(err_idle_tag), 32'h1);
    repeat (2) step();
    chk("err_sticky", 32'(err_idle_tag), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("err_cleared", 32'(err_idle_tag), 32'h0);

    // Fill, then reset mid-stream
    for (int i = 0; i < NSRC; i++)
      for (int j = 0; j < 3; j++) stim[i].push_back('{4'($urandom_range(0, 14)), 8'($urandom)});
    repeat (3) step();
    rst = 1'b1;
    for (int i = 0; i < NSRC; i++) stim[i].delete();
    src_valid = '0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(cdb_valid), 32'h0);
    chk("post_rst_ready", 32'(src_ready), 32'hF);

    // Random sustained traffic with the counter preloaded near wrap
    force dut.bcast_count = 16'hFFFF;
    #1;
    release dut.bcast_count;
    m_cnt = 16'hFFFF;
    for (int n = 0; n < 320; n++) begin
      for (int i = 0; i < NSRC; i++)
        if (stim[i].size() < 2 && $urandom_range(0, 3) != 0)
          stim[i].push_back('{4'($urandom_range(0, 14)), 8'($urandom)});
      step();
    end
    chk("wrap_count", 32'(bcast_count < 16'd400), 32'h1);
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
